// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO arbiter and the FIFO it fronts.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 8;

endpackage

// File: rtl/arb2_rr.sv
// Two-way push arbiter. FIFO_ARB_RR_EN selects round-robin on ties; otherwise
// producer 0 has fixed priority and no pointer state exists.
module arb2_rr (
`ifdef FIFO_ARB_RR_EN
  input  logic       clk,
  input  logic       FIFO_reset_n,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef FIFO_ARB_RR_EN
  logic last_gnt;  // 1 = producer 1 was granted most recently

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
  end

  // NOTE: state is written with non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!FIFO_reset_n) last_gnt <= 1'b1;
    else if (|gnt)     last_gnt <= gnt[1];
  end
`else
  always_comb begin
    gnt = req;
    if (req[0]) gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// Shares one FIFO between two producers and a consumer, tracking occupancy.
// Build option: FIFO_ARB_RR_EN enables round-robin tie breaking on pushes.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CLR_CYCLES = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              FIFO_reset_n,
  input  logic              wr_req_0,
  input  logic              wr_req_1,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic [DATA_W-1:0] wr_data_1,
  output logic              wr_gnt_0,
  output logic              wr_gnt_1,
  input  logic              rd_req,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_req,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              fifo_push,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] fifo_data_in,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_clr_n
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic             run_open;
  logic             push_ok;
  logic             push_acc;
  logic             pop_acc;
  logic [1:0]       gnt;

  // A clear request closes both ports in the same cycle it is seen.
  assign run_open = (state == RUN) && !clr_req;
  assign push_ok  = run_open && (count < CNT_W'(DEPTH));
  assign rd_gnt   = run_open && (count != '0);

  arb2_rr u_arb (
`ifdef FIFO_ARB_RR_EN
    .clk          (clk),
    .FIFO_reset_n (FIFO_reset_n),
`endif
    .req          ({wr_req_1, wr_req_0} & {2{push_ok}}),
    .gnt          (gnt)
  );

  assign wr_gnt_0 = gnt[0];
  assign wr_gnt_1 = gnt[1];
  assign push_acc = |gnt;
  assign pop_acc  = rd_req & rd_gnt;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign rd_data  = fifo_data_out;

  always_ff @(posedge clk) begin
    if (!FIFO_reset_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      fifo_clr_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state      <= CLEAR;
          clr_cnt    <= '0;
          fifo_clr_n <= 1'b0;
        end
        CLEAR: begin
          if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
            state      <= RUN;
            fifo_clr_n <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        RUN: begin
          if (clr_req) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            fifo_clr_n <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin pipeline and occupancy; rd_valid is suppressed across any clear window.
  always_ff @(posedge clk) begin
    if (!FIFO_reset_n) begin
      count        <= '0;
      fifo_push    <= 1'b0;
      fifo_pop     <= 1'b0;
      fifo_data_in <= '0;
      rd_valid     <= 1'b0;
    end else begin
      fifo_push <= push_acc;
      fifo_pop  <= pop_acc;
      rd_valid  <= fifo_pop && run_open;
      if (push_acc) fifo_data_in <= gnt[1] ? wr_data_1 : wr_data_0;
      if (!run_open) begin
        count <= '0;
      end else begin
        case ({push_acc, pop_acc})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a behavioural FIFO on the pin side.
module tb_fifo_arbiter;

  logic       clk;
  logic       FIFO_reset_n;
  logic       wr_req_0, wr_req_1;
  logic [7:0] wr_data_0, wr_data_1;
  logic       wr_gnt_0, wr_gnt_1;
  logic       rd_req, rd_gnt, rd_valid;
  logic [7:0] rd_data;
  logic       clr_req;
  logic [3:0] count;
  logic       full, empty;
  logic       fifo_push, fifo_pop;
  logic [7:0] fifo_data_in;
  logic [7:0] fifo_data_out;
  logic       fifo_clr_n;

  int checks   = 0;
  int failures = 0;

  fifo_arbiter dut (
    .clk           (clk),
    .FIFO_reset_n  (FIFO_reset_n),
    .wr_req_0      (wr_req_0),
    .wr_req_1      (wr_req_1),
    .wr_data_0     (wr_data_0),
    .wr_data_1     (wr_data_1),
    .wr_gnt_0      (wr_gnt_0),
    .wr_gnt_1      (wr_gnt_1),
    .rd_req        (rd_req),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .clr_req       (clr_req),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .fifo_push     (fifo_push),
    .fifo_pop      (fifo_pop),
    .fifo_data_in  (fifo_data_in),
    .fifo_data_out (fifo_data_out),
    .fifo_clr_n    (fifo_clr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: data_out is valid the cycle after pop is sampled.
  logic [7:0] model_q[$];
  always @(posedge clk) begin
    if (!FIFO_reset_n || !fifo_clr_n) begin
      model_q.delete();
      fifo_data_out <= 8'h00;
    end else begin
      if (fifo_push) model_q.push_back(fifo_data_in);
      if (fifo_pop && model_q.size() > 0) fifo_data_out <= model_q.pop_front();
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    wr_req_0  = 1'b0;
    wr_req_1  = 1'b0;
    wr_data_0 = 8'h00;
    wr_data_1 = 8'h00;
    rd_req    = 1'b0;
    clr_req   = 1'b0;
  endtask

  task automatic reset_dut;
    idle_inputs();
    FIFO_reset_n = 1'b0;
    tick();
    tick();
    FIFO_reset_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    FIFO_reset_n = 1'b0;
    wr_req_0     = 1'b1;
    wr_data_0    = 8'h77;
    tick();
    tick();
    settle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b want 0", full); end
    checks++; if ({fifo_push, fifo_pop, rd_valid} !== 3'b000) begin failures++; $display("FAIL rst_pins: push/pop/valid got %b want 000", {fifo_push, fifo_pop, rd_valid}); end
    checks++; if (fifo_data_in !== 8'h00) begin failures++; $display("FAIL rst_data_in: got %h want 00", fifo_data_in); end
    checks++; if (fifo_clr_n !== 1'b1) begin failures++; $display("FAIL rst_clr_n: got %b want 1", fifo_clr_n); end
    checks++; if (wr_gnt_0 !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %b want 0", wr_gnt_0); end
    FIFO_reset_n = 1'b1;
    settle();
    checks++; if ({fifo_clr_n, wr_gnt_0} !== 2'b10) begin failures++; $display("FAIL cyc1_idle: clr_n/gnt got %b want 10", {fifo_clr_n, wr_gnt_0}); end
    tick();
    checks++; if ({fifo_clr_n, wr_gnt_0} !== 2'b00) begin failures++; $display("FAIL cyc2_clear: clr_n/gnt got %b want 00", {fifo_clr_n, wr_gnt_0}); end
    tick();
    checks++; if ({fifo_clr_n, wr_gnt_0} !== 2'b00) begin failures++; $display("FAIL cyc3_clear: clr_n/gnt got %b want 00", {fifo_clr_n, wr_gnt_0}); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL cyc3_count: got %0d want 0", count); end
    tick();
    checks++; if ({fifo_clr_n, wr_gnt_0} !== 2'b11) begin failures++; $display("FAIL cyc4_run: clr_n/gnt got %b want 11", {fifo_clr_n, wr_gnt_0}); end
    wr_req_0 = 1'b0;
  endtask

  task automatic test_push_pop;
    reset_dut();
    wr_req_0  = 1'b1;
    wr_data_0 = 8'h11;
    settle();
    checks++; if (wr_gnt_0 !== 1'b1) begin failures++; $display("FAIL pp_gnt_a: got %b want 1", wr_gnt_0); end
    tick();
    checks++; if ({fifo_push, fifo_data_in, count} !== {1'b1, 8'h11, 4'd1}) begin failures++; $display("FAIL pp_push_a: push/data/count got %b/%h/%0d want 1/11/1", fifo_push, fifo_data_in, count); end
    wr_data_0 = 8'h22;
    tick();
    checks++; if ({fifo_push, fifo_data_in, count} !== {1'b1, 8'h22, 4'd2}) begin failures++; $display("FAIL pp_push_b: push/data/count got %b/%h/%0d want 1/22/2", fifo_push, fifo_data_in, count); end
    wr_req_0 = 1'b0;
    rd_req   = 1'b1;
    settle();
    checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL pp_rd_gnt: got %b want 1", rd_gnt); end
    tick();
    checks++; if ({fifo_pop, rd_valid, count} !== {1'b1, 1'b0, 4'd1}) begin failures++; $display("FAIL pp_pop1: pop/valid/count got %b/%b/%0d want 1/0/1", fifo_pop, rd_valid, count); end
    tick();
    rd_req = 1'b0;
    checks++; if ({rd_valid, rd_data, count} !== {1'b1, 8'h11, 4'd0}) begin failures++; $display("FAIL pp_data1: valid/data/count got %b/%h/%0d want 1/11/0", rd_valid, rd_data, count); end
    tick();
    checks++; if ({rd_valid, rd_data, empty} !== {1'b1, 8'h22, 1'b1}) begin failures++; $display("FAIL pp_data2: valid/data/empty got %b/%h/%b want 1/22/1", rd_valid, rd_data, empty); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL pp_valid_end: got %b want 0", rd_valid); end
  endtask

  task automatic test_rr_fill;
    logic exp0;
    reset_dut();
    wr_req_0  = 1'b1;
    wr_req_1  = 1'b1;
    wr_data_0 = 8'hA0;
    wr_data_1 = 8'hB0;
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      settle();
      checks++; if ({wr_gnt_0, wr_gnt_1} !== {exp0, ~exp0}) begin failures++; $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", i, wr_gnt_0, wr_gnt_1, exp0, ~exp0); end
      tick();
      checks++; if ({fifo_push, fifo_data_in, count} !== {1'b1, (exp0 ? 8'hA0 : 8'hB0), 4'(i + 1)}) begin failures++; $display("FAIL rr_push[%0d]: push/data/count got %b/%h/%0d want 1/%h/%0d", i, fifo_push, fifo_data_in, count, exp0 ? 8'hA0 : 8'hB0, i + 1); end
    end
    settle();
    checks++; if ({full, wr_gnt_0, wr_gnt_1} !== 3'b100) begin failures++; $display("FAIL rr_full: full/gnt0/gnt1 got %b want 100", {full, wr_gnt_0, wr_gnt_1}); end
    rd_req = 1'b1;
    settle();
    checks++; if ({rd_gnt, wr_gnt_0, wr_gnt_1} !== 3'b100) begin failures++; $display("FAIL full_both: rd/wr0/wr1 gnt got %b want 100", {rd_gnt, wr_gnt_0, wr_gnt_1}); end
    tick();
    rd_req   = 1'b0;
    wr_req_0 = 1'b0;
    wr_req_1 = 1'b0;
    checks++; if ({count, full, fifo_pop, fifo_push} !== {4'd7, 1'b0, 1'b1, 1'b0}) begin failures++; $display("FAIL full_pop: count/full/pop/push got %0d/%b/%b/%b want 7/0/1/0", count, full, fifo_pop, fifo_push); end
    tick();
    checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hA0}) begin failures++; $display("FAIL full_data: valid/data got %b/%h want 1/a0", rd_valid, rd_data); end
  endtask

  task automatic test_same_cycle;
    reset_dut();
    wr_req_0  = 1'b1;
    wr_data_0 = 8'h5C;
    rd_req    = 1'b1;
    settle();
    checks++; if ({wr_gnt_0, rd_gnt} !== 2'b10) begin failures++; $display("FAIL sc_gnts: wr/rd got %b want 10", {wr_gnt_0, rd_gnt}); end
    tick();
    wr_req_0 = 1'b0;
    settle();
    checks++; if ({count, rd_gnt} !== {4'd1, 1'b1}) begin failures++; $display("FAIL sc_next: count/rd_gnt got %0d/%b want 1/1", count, rd_gnt); end
    tick();
    rd_req = 1'b0;
    checks++; if ({count, fifo_pop} !== {4'd0, 1'b1}) begin failures++; $display("FAIL sc_pop: count/pop got %0d/%b want 0/1", count, fifo_pop); end
    tick();
    checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h5C}) begin failures++; $display("FAIL sc_data: valid/data got %b/%h want 1/5c", rd_valid, rd_data); end
  endtask

  task automatic test_clear;
    reset_dut();
    wr_req_0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data_0 = 8'(i);
      tick();
    end
    wr_req_0 = 1'b0;
    tick();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL clr_pre_count: got %0d want 3", count); end
    rd_req = 1'b1;
    tick();
    rd_req   = 1'b0;
    clr_req  = 1'b1;
    wr_req_0 = 1'b1;
    settle();
    checks++; if ({wr_gnt_0, rd_gnt, fifo_pop, count} !== {1'b0, 1'b0, 1'b1, 4'd2}) begin failures++; $display("FAIL clr_req_cyc: wr/rd gnt/pop/count got %b/%b/%b/%0d want 0/0/1/2", wr_gnt_0, rd_gnt, fifo_pop, count); end
    tick();
    clr_req = 1'b0;
    checks++; if ({fifo_clr_n, count, rd_valid, wr_gnt_0} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL clr_cyc1: clr_n/count/valid/gnt got %b/%0d/%b/%b want 0/0/0/0", fifo_clr_n, count, rd_valid, wr_gnt_0); end
    tick();
    checks++; if ({fifo_clr_n, rd_valid, wr_gnt_0} !== 3'b000) begin failures++; $display("FAIL clr_cyc2: clr_n/valid/gnt got %b want 000", {fifo_clr_n, rd_valid, wr_gnt_0}); end
    tick();
    wr_req_0 = 1'b0;
    rd_req   = 1'b1;
    settle();
    checks++; if ({fifo_clr_n, count, rd_valid, rd_gnt} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL clr_run: clr_n/count/valid/rd_gnt got %b/%0d/%b/%b want 1/0/0/0", fifo_clr_n, count, rd_valid, rd_gnt); end
    tick();
    rd_req = 1'b0;
    checks++; if ({rd_valid, fifo_pop} !== 2'b00) begin failures++; $display("FAIL clr_after: valid/pop got %b want 00", {rd_valid, fifo_pop}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_push_pop();
    test_rr_fill();
    test_same_cycle();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
